// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg: definitions shared by the audio equalizer blocks.
//   DATA_W        sample width per channel
//   HF_TAPS       high-pass FIR coefficient count (readout window length)
//   HF_DEPTH      high-pass sample queue depth (must exceed HF_TAPS)
//   queue_state_t readout sequencer states of hf_sample_queue
// No ports; imported by the equalizer RTL.
// ---------------------------------------------------------------------------
package eq_pkg;

    localparam int DATA_W   = 16;
    localparam int HF_TAPS  = 1021;
    localparam int HF_DEPTH = 1536;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } queue_state_t;

endpackage

// File: rtl/hfq_dp_ram.sv
// ---------------------------------------------------------------------------
// hfq_dp_ram: simple dual-port sample RAM, DEPTH x WIDTH.
// One write port and one registered read port with 1-cycle read latency.
// Memory contents are never reset; only the read data register is cleared
// by rst_n so the downstream sample outputs start at zero.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (read register only)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata holds its value while re is low
//   raddr  read address
//   rdata  registered read data
// ---------------------------------------------------------------------------
module hfq_dp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hf_sample_queue.sv
// ---------------------------------------------------------------------------
// hf_sample_queue: circular left/right sample buffer feeding the high-pass
// FIR. Every write that leaves TAPS samples held requests a readout burst
// that streams the TAPS newest pairs, oldest first, under `sequencing`.
// A burst is TAPS+1 cycles: cycle 0 lets the FIR clear its accumulator
// while the first RAM read is in flight, cycles 1..TAPS carry samples.
// One GAP cycle follows so the FIR falls back to IDLE between bursts.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wrt_smpl   one-cycle strobe, lft_smpl/rght_smpl valid
//   lft_smpl   left sample in
//   rght_smpl  right sample in
//   lft_out    left sample to FIR (held while sequencing is low)
//   rght_out   right sample to FIR (held while sequencing is low)
//   sequencing readout envelope to FIR
//   full       TAPS samples are held
//   overrun    (only with HFQ_OVERRUN_EN) sticky: a write arrived while a
//              burst request was already pending, so readouts were merged
// ---------------------------------------------------------------------------
module hf_sample_queue
    import eq_pkg::*;
#(
    parameter int DATA_W = eq_pkg::DATA_W,
    parameter int TAPS   = HF_TAPS,
    parameter int DEPTH  = HF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic [DATA_W-1:0] lft_smpl,
    input  logic [DATA_W-1:0] rght_smpl,
    output logic [DATA_W-1:0] lft_out,
    output logic [DATA_W-1:0] rght_out,
    output logic              sequencing,
    output logic              full
`ifdef HFQ_OVERRUN_EN
   ,output logic              overrun
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);

    queue_state_t      state;
    logic [AW-1:0]     new_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fill_cnt;
    logic [CW-1:0]     fill_nxt;
    logic [CW-1:0]     idx;
    logic              pending;
    logic              trigger;
    logic              rd_en;
    logic [2*DATA_W-1:0] rd_data;

    // DEPTH need not be a power of two, so wrap by compare.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Oldest entry of the window ending just before p, modulo DEPTH.
    function automatic logic [AW-1:0] win_start(input logic [AW-1:0] p);
        return (p >= AW'(TAPS)) ? p - AW'(TAPS) : p + AW'(DEPTH - TAPS);
    endfunction

    assign fill_nxt = (fill_cnt == CW'(TAPS)) ? fill_cnt : fill_cnt + 1'b1;
    assign trigger  = wrt_smpl && (fill_nxt == CW'(TAPS));
    // No read on the final READ cycle, so the last sample stays on the bus.
    assign rd_en    = (state == READ) && (idx != CW'(TAPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr  <= '0;
            fill_cnt <= '0;
            full     <= 1'b0;
        end else if (wrt_smpl) begin
            new_ptr  <= ptr_inc(new_ptr);
            fill_cnt <= fill_nxt;
            full     <= (fill_nxt == CW'(TAPS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sequencing <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending    <= 1'b0;
                        rd_ptr     <= win_start(new_ptr);
                        idx        <= '0;
                        sequencing <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    rd_ptr <= ptr_inc(rd_ptr);
                    if (idx == CW'(TAPS)) begin
                        sequencing <= 1'b0;
                        state      <= GAP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    sequencing <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            // A new request overrides the clear issued when IDLE consumes one.
            if (trigger) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef HFQ_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (wrt_smpl && pending) begin
            overrun <= 1'b1;
        end
    end
`endif

    hfq_dp_ram #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wrt_smpl),
        .waddr (new_ptr),
        .wdata ({lft_smpl, rght_smpl}),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign lft_out  = rd_data[2*DATA_W-1:DATA_W];
    assign rght_out = rd_data[DATA_W-1:0];

endmodule

// File: doc/hf_sample_queue.md
Name: hf_sample_queue

Overview:
- Circular sample buffer sitting directly upstream of the high-pass FIR stage in the audio equalizer.
- Stores incoming left/right 16-bit sample pairs on each wrt_smpl strobe.
- Once TAPS samples are held, every new write triggers a readout burst. The burst streams the TAPS most recent pairs, oldest first, under a `sequencing` envelope timed for the FIR's IDLE/MAC handshake.

Parameters:
- DATA_W, 16, sample width per channel.
- TAPS, 1021, samples per readout window (equals FIR coefficient count).
- DEPTH, 1536, buffer entries; must be > TAPS; pointer width = $clog2(DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wrt_smpl  input  1  one-cycle strobe: lft_smpl/rght_smpl valid, write them
- lft_smpl  input  DATA_W  left sample in
- rght_smpl  input  DATA_W  right sample in
- lft_out  output  DATA_W  left sample to FIR
- rght_out  output  DATA_W  right sample to FIR
- sequencing  output  1  readout envelope to FIR
- full  output  1  fill count has reached TAPS

Behaviour:
- Reset (async, rst_n low):
  - new_ptr=0, rd_ptr=0, fill_cnt=0, pending=0, state=IDLE.
  - sequencing=0, full=0, lft_out=0, rght_out=0.
  - RAM contents are not reset.
- Write:
  - In the cycle wrt_smpl=1, the pair is written to RAM[new_ptr] at that clock edge.
  - new_ptr increments, wrapping DEPTH-1 -> 0.
  - fill_cnt increments, saturating at TAPS; full = (fill_cnt == TAPS).
  - Writes are accepted in every state.
- Trigger: a write that leaves fill_cnt == TAPS sets `pending`. This includes the write that first fills the buffer.
- States: IDLE, READ, GAP.
- IDLE:
  - If pending: clear pending, load rd_ptr = (new_ptr - TAPS) mod DEPTH using the post-write new_ptr, reset the index counter, and go to READ.
  - Sequencing rises the cycle after the triggering write edge.
- READ:
  - sequencing=1 for exactly TAPS+1 consecutive cycles.
  - Cycle 0 issues the RAM read of rd_ptr; no valid data on the outputs.
  - Cycles 1..TAPS: lft_out/rght_out hold window sample k = cycle-1 (k=0 oldest, k=TAPS-1 the just-written sample).
  - rd_ptr increments every cycle with wrap.
  - After cycle TAPS, go to GAP.
  - This matches the FIR: the first sequencing cycle clears its accumulator, and each following cycle accumulates one product with a 1-cycle-latency coefficient.
- GAP:
  - sequencing=0 for one cycle, then go to IDLE.
  - The gap guarantees the FIR returns to IDLE between bursts.
- Outputs: lft_out/rght_out are the registered RAM read data. They hold their last value whenever sequencing=0.
- Write during READ/GAP:
  - The write lands at new_ptr, which lies outside the active window because DEPTH > TAPS. No corruption.
  - pending is set and the next burst starts from IDLE after GAP.
  - A further write while pending=1 is stored, but pending stays a single bit: that readout is merged, and the next burst uses the window current when it starts.
- Wrap: pointer arithmetic is mod DEPTH. DEPTH need not be a power of 2; use an explicit compare-and-wrap.
- Reset mid-burst: sequencing drops immediately (async), the buffer is empty again (fill_cnt=0), and no burst occurs until TAPS new writes.

Optional Feature:
- Macro HFQ_OVERRUN_EN.
- Defined:
  - Adds output port `overrun` (1 bit).
  - Sticky; set on the cycle after any write that arrives while pending is already 1.
  - Cleared only by rst_n.
- Undefined: port and logic absent; merging behaviour unchanged.

Decomposition:
- Shared package eq_pkg:
  - localparams DATA_W, HF_TAPS=1021, HF_DEPTH=1536.
  - typedef enum logic [1:0] {IDLE, READ, GAP} queue_state_t.
- Sub-module hfq_dp_ram:
  - Simple dual-port RAM, DEPTH x (2*DATA_W).
  - One write port, one registered read port, 1-cycle read latency, no reset on contents.
  - Output register has async reset to 0 so lft_out/rght_out reset correctly.

Test Plan (bench overrides TAPS=5, DEPTH=8):
- Reset with rst_n=0 -> sequencing=0, full=0, lft_out=rght_out=0. Write 4 samples (values 1..4, right = value+100) -> no sequencing, full=0.
- Write 5th sample (5) -> full=1; sequencing high 6 cycles starting the cycle after the write; cycles 1..5 lft_out=1,2,3,4,5 and rght_out=101..105; then one low cycle.
- Write samples 6..12, spaced 20 cycles apart, so new_ptr wraps past 7 -> the burst for sample 12 outputs 8,9,10,11,12 in order.
- Write sample 13 on cycle 2 of an active burst -> current burst completes unchanged (9..12 tail intact); after 1 GAP cycle a new burst outputs 9..13.
- Two writes (14, 15) during one burst -> one merged burst outputs 11..15; with HFQ_OVERRUN_EN, overrun=1 and stays 1 until reset.
- Assert rst_n=0 at cycle 3 of a burst -> sequencing=0 immediately; after release, 4 writes produce no burst and the 5th does.
